ram_banked: RTL and testbench

RAM_BANKED -- requirements
Module: ram_banked

---
 rtl/hack_mem_pkg.sv | 14 +
 rtl/ram_bank.sv | 30 +++
 rtl/ram_banked.sv | 121 ++++++++++++
 tb/tb_ram_banked.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types and default geometry for the banked RAM: the sweep FSM
// state encoding and the default word/address/bank widths.
package hack_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_REG_W  = 16;
  localparam int DEF_ADD_W  = 6;
  localparam int DEF_BANK_W = 3;

endpackage

// File: rtl/ram_bank.sv
// One memory bank: REG_W x 2**ROW_W words, one synchronous write port and
// one asynchronous read port.
module ram_bank
  import hack_mem_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int ROW_W = DEF_ADD_W - DEF_BANK_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [REG_W-1:0] data,
  input  logic [ROW_W-1:0] rd_row,
  output logic [REG_W-1:0] q
);

  localparam int ROWS = 2 ** ROW_W;

  // No reset on the array: the top clears it with a sweep after reset.
  logic [REG_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row] <= data;
    end
  end

  assign q = mem[rd_row];

endmodule

// File: rtl/ram_banked.sv
// Banked word RAM with a row-parallel clear sweep. Reset and `clear` both
// start a sweep that zeroes one row of every bank per cycle.
// Optional registered read port: define RAM_BANKED_REGOUT_EN.
module ram_banked
  import hack_mem_pkg::*;
#(
  parameter int REG_W  = DEF_REG_W,
  parameter int ADD_W  = DEF_ADD_W,
  parameter int BANK_W = DEF_BANK_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] in,
  input  logic             load,
  input  logic [ADD_W-1:0] address,
  input  logic             clear,
  output logic [REG_W-1:0] out,
  output logic             busy,
  output logic             clr_done
);

  localparam int ROW_W = ADD_W - BANK_W;
  localparam int NB    = 2 ** BANK_W;

  // FSM state is kept as a named enum register for observation.
  state_t           state;
  state_t           state_nxt;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_nxt;

  logic [BANK_W-1:0] bank_sel;
  logic [ROW_W-1:0]  addr_row;
  logic              accept_load;
  logic              sweep_wr;
  logic [ROW_W-1:0]  wr_row;
  logic [REG_W-1:0]  wr_data;
  logic [REG_W-1:0]  rd_data [NB];
  logic [REG_W-1:0]  rd_word;

  assign bank_sel = address[ADD_W-1 -: BANK_W];
  assign addr_row = address[ROW_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      row   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          row_nxt   = '0;
        end
      end
      CLEAR: begin
        if (&row) begin
          state_nxt = IDLE;
          row_nxt   = '0;
        end else begin
          row_nxt = row + 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
        row_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);
  // A reset on the last row restarts the sweep, so that cycle is not a completion.
  assign clr_done = !reset && (state == CLEAR) && (&row);

  assign accept_load = !reset && (state == IDLE) && load && !clear;
  assign sweep_wr    = !reset && (state == CLEAR);
  assign wr_row      = sweep_wr ? row : addr_row;
  assign wr_data     = sweep_wr ? '0 : in;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic bank_we;
    assign bank_we = sweep_wr || (accept_load && (bank_sel == BANK_W'(b)));

    ram_bank #(
      .REG_W (REG_W),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk    (clk),
      .we     (bank_we),
      .wr_row (wr_row),
      .data   (wr_data),
      .rd_row (addr_row),
      .q      (rd_data[b])
    );
  end

  assign rd_word = rd_data[bank_sel];

`ifdef RAM_BANKED_REGOUT_EN
  // Write-through: an accepted load shows its own data on the next cycle.
  always_ff @(posedge clk) begin
    if (reset || (state == CLEAR)) begin
      out <= '0;
    end else if (accept_load) begin
      out <= in;
    end else begin
      out <= rd_word;
    end
  end
`else
  assign out = (state == IDLE) ? rd_word : '0;
`endif

endmodule

// File: tb/tb_ram_banked.sv
// Randomized bench for ram_banked against a word-level memory model, plus
// directed sweep/reset/write scenarios with literal expectations.
module tb_ram_banked;

  localparam int REG_W  = 16;
  localparam int ADD_W  = 6;
  localparam int BANK_W = 3;
  localparam int ROWS   = 2 ** (ADD_W - BANK_W);
  localparam int DEPTH  = 2 ** ADD_W;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic             clear;
  logic [REG_W-1:0] din;
  logic [ADD_W-1:0] address;
  logic [REG_W-1:0] dout;
  logic             busy;
  logic             clr_done;

  always #5 clk = ~clk;

  ram_banked #(
    .REG_W  (REG_W),
    .ADD_W  (ADD_W),
    .BANK_W (BANK_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .load     (load),
    .address  (address),
    .clear    (clear),
    .out      (dout),
    .busy     (busy),
    .clr_done (clr_done)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int done_pulses = 0;
  logic [REG_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory as a flat word array; a sweep is just "cycles left busy".
  // Zeroing the whole array when the sweep starts is observably the same,
  // since reads return 0 and writes are ignored until it finishes.
  logic [REG_W-1:0] mem_m [DEPTH];
  int               sweep_left  = 0;
  bit               model_valid = 1'b0;
`ifdef RAM_BANKED_REGOUT_EN
  logic [REG_W-1:0] out_m = '0;
`endif

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
`ifdef RAM_BANKED_REGOUT_EN
      out_m = '0;
`endif
      sweep_left  = ROWS;
      model_valid = 1'b1;
      zero_model();
    end else if (sweep_left > 0) begin
`ifdef RAM_BANKED_REGOUT_EN
      out_m = '0;
`endif
      sweep_left--;
    end else begin
`ifdef RAM_BANKED_REGOUT_EN
      out_m = (load && !clear) ? din : mem_m[address];
`endif
      if (clear) begin
        sweep_left = ROWS;
        zero_model();
      end else if (load) begin
        mem_m[address] = din;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    #2;
    if (model_valid) begin
      check("busy", busy, (sweep_left > 0));
      check("clr_done", clr_done, (!reset && sweep_left == 1));
`ifdef RAM_BANKED_REGOUT_EN
      exp_q.push_back(out_m);
`else
      exp_q.push_back((sweep_left > 0) ? '0 : mem_m[address]);
`endif
      check("out", dout, exp_q.pop_front());
      if (clr_done === 1'b1) done_pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [ADD_W-1:0] a, input logic [REG_W-1:0] d);
    @(negedge clk);
    load = 1'b1; clear = 1'b0; address = a; din = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [ADD_W-1:0] a,
                            input logic [REG_W-1:0] e);
    @(negedge clk);
    address = a; load = 1'b0; clear = 1'b0;
`ifdef RAM_BANKED_REGOUT_EN
    @(negedge clk);
`endif
    #2;
    check(name, dout, e);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1; load = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Called right after inputs were driven at a negedge.
  task automatic measure_sweep(output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = 0;
    for (int i = 1; i <= ROWS + 4; i++) begin
      #2;
      if (busy === 1'b1) busy_n++;
      if (clr_done === 1'b1) done_at = i;
      if (busy !== 1'b1) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bn, da, d0;
    reset = 1'b1; load = 1'b0; clear = 1'b0; din = '0; address = '0;

    // Reset held two cycles, then one full sweep.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_pulses;
    measure_sweep(bn, da);
    check("rst_sweep_busy_cycles", bn, ROWS);
    check("rst_sweep_done_cycle", da, ROWS);
    check("rst_sweep_done_count", done_pulses - d0, 1);
    for (int a = 0; a < DEPTH; a++) read_check("zero_after_reset", a[ADD_W-1:0], 16'h0000);

    // Single write lands in one bank only.
    write_word(6'h2A, 16'h1234);
    read_check("wr_2a", 6'h2A, 16'h1234);
    read_check("other_bank_22", 6'h22, 16'h0000);
    read_check("other_bank_32", 6'h32, 16'h0000);

    // Clear with a simultaneous load: load dropped.
    write_word(6'd5, 16'h5555);
    read_check("pre_clear_5", 6'd5, 16'h5555);
    @(negedge clk);
    clear = 1'b1; load = 1'b1; address = 6'd5; din = 16'hBEEF;
    @(negedge clk);
    clear = 1'b0; load = 1'b0;
    d0 = done_pulses;
    measure_sweep(bn, da);
    check("clr_sweep_busy_cycles", bn, ROWS);
    check("clr_sweep_done_cycle", da, ROWS);
    check("clr_sweep_done_count", done_pulses - d0, 1);
    read_check("clr_addr5", 6'd5, 16'h0000);
    read_check("clr_addr2a", 6'h2A, 16'h0000);

    // Reset in the middle of a sweep restarts it.
    write_word(6'h11, 16'hAAAA);
    pulse_clear();
    d0 = done_pulses;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure_sweep(bn, da);
    check("restart_busy_cycles", bn, ROWS);
    check("restart_done_cycle", da, ROWS);
    check("restart_done_count", done_pulses - d0, 1);
    read_check("restart_addr11", 6'h11, 16'h0000);

    // Loads during a sweep are ignored.
    write_word(6'd9, 16'h1111);
    pulse_clear();
    load = 1'b1; address = 6'd9; din = 16'h7777;
    repeat (6) @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < ROWS && busy === 1'b1; i++) @(negedge clk);
    #2;
    check("busy_load_idle", busy, 1'b0);
    read_check("busy_load_addr9", 6'd9, 16'h0000);

`ifdef RAM_BANKED_REGOUT_EN
    // Registered read: write-through and one-cycle address latency.
    write_word(6'd4, 16'h4444);
    @(negedge clk);
    load = 1'b1; address = 6'd3; din = 16'h00FF;
    @(negedge clk);
    load = 1'b0; address = 6'd4;
    #2;
    check("regout_write_through", dout, 16'h00FF);
    @(negedge clk);
    #2;
    check("regout_addr_latency", dout, 16'h4444);
`endif

    // Randomized traffic against the model.
    repeat (3000) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 39) == 0);
      load    = $urandom_range(0, 1) == 1;
      address = ADD_W'($urandom_range(0, DEPTH - 1));
      din     = REG_W'($urandom_range(0, 16'hFFFF));
    end
    @(negedge clk);
    reset = 1'b0; clear = 1'b0; load = 1'b0;
    repeat (ROWS + 2) @(negedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
